// File: rtl/rv_ctrl_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rv_ctrl_sequencer                                            |
// | Description : Multi-cycle control sequencer for a FemtoRV-style datapath.  |
// |               Produces latch / write-enable strobes and memory strobes,    |
// |               with load/store wait states, EBREAK halt/resume, single-step |
// |               debug control and a bus-timeout fault.                       |
// |               Optional macro CTRL_PERF_EN adds cycle/stall counters.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rv_ctrl_sequencer #(
  parameter int RESET_HALTED = 0,
  parameter int BUS_TIMEOUT  = 255,
  parameter int COUNT_W      = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_system,
  input  logic               writes_rd,
  input  logic               rd_nonzero,
  input  logic               mem_rbusy,
  input  logic               mem_wbusy,
  input  logic               run_mode,
  input  logic               step_req,
  input  logic               resume,
  output logic               mem_rstrb,
  output logic               mem_wstrb,
  output logic               mem_addr_sel,
  output logic               instr_we,
  output logic               regs_we,
  output logic               pc_we,
  output logic               rf_we,
  output logic               rf_sel_load,
  output logic               halted,
  output logic               fault,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]        cycle_count,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [3:0] S_FETCH_INSTR = 4'd0;
  localparam logic [3:0] S_WAIT_INSTR  = 4'd1;
  localparam logic [3:0] S_FETCH_REGS  = 4'd2;
  localparam logic [3:0] S_EXECUTE     = 4'd3;
  localparam logic [3:0] S_LOAD        = 4'd4;
  localparam logic [3:0] S_WAIT_DATA   = 4'd5;
  localparam logic [3:0] S_STORE       = 4'd6;
  localparam logic [3:0] S_WAIT_STORE  = 4'd7;
  localparam logic [3:0] S_HALT        = 4'd8;
  localparam logic [3:0] S_FAULT       = 4'd9;

  localparam logic [3:0] RESET_STATE = (RESET_HALTED != 0) ? S_HALT : S_FETCH_INSTR;
  localparam bit         TO_EN       = (BUS_TIMEOUT != 0);
  localparam logic [7:0] TO_LAST     = 8'(BUS_TIMEOUT - 1);

  logic [3:0] cur_state;
  logic [3:0] nxt_state;
  logic       step_pending;
  logic [7:0] to_count;

  logic       can_go;
  logic       in_wait;
  logic       busy_now;
  logic       timed_out;

  // raw (ungated) strobes and bookkeeping events from the output decoder
  logic       rstrb_raw;
  logic       wstrb_raw;
  logic       addr_sel_raw;
  logic       instr_we_raw;
  logic       regs_we_raw;
  logic       pc_we_raw;
  logic       rf_we_raw;
  logic       rf_sel_raw;
  logic       retire;
  logic       consume_step;

  // A fetch may start in free-run mode or when a single step is armed.
  assign can_go   = run_mode | step_pending;
  assign in_wait  = (cur_state == S_WAIT_INSTR) || (cur_state == S_WAIT_DATA) ||
                    (cur_state == S_WAIT_STORE);
  assign busy_now = ((cur_state == S_WAIT_INSTR) || (cur_state == S_WAIT_DATA)) ? mem_rbusy :
                    (cur_state == S_WAIT_STORE) ? mem_wbusy : 1'b0;
  // The bus is declared dead when the last allowed busy cycle is still busy.
  assign timed_out = TO_EN && in_wait && busy_now && (to_count == TO_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) cur_state <= RESET_STATE;
    else         cur_state <= nxt_state;
  end

  // Next-state decode.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_FETCH_INSTR: if (can_go) nxt_state = S_WAIT_INSTR;
      S_WAIT_INSTR: begin
        if (timed_out)       nxt_state = S_FAULT;
        else if (!mem_rbusy) nxt_state = S_FETCH_REGS;
      end
      S_FETCH_REGS: nxt_state = S_EXECUTE;
      S_EXECUTE: begin
        if (is_system)     nxt_state = S_HALT;
        else if (is_load)  nxt_state = S_LOAD;
        else if (is_store) nxt_state = S_STORE;
        else               nxt_state = S_FETCH_INSTR;
      end
      S_LOAD: nxt_state = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (timed_out)       nxt_state = S_FAULT;
        else if (!mem_rbusy) nxt_state = S_FETCH_INSTR;
      end
      S_STORE: nxt_state = S_WAIT_STORE;
      S_WAIT_STORE: begin
        if (timed_out)       nxt_state = S_FAULT;
        else if (!mem_wbusy) nxt_state = S_FETCH_INSTR;
      end
      S_HALT:  if (resume) nxt_state = S_FETCH_INSTR;
      S_FAULT: nxt_state = S_FAULT;
      // Unreachable codes are treated as a fault rather than silently resumed.
      default: nxt_state = S_FAULT;
    endcase
  end

  // Output decode from the registered state and current inputs.
  always_comb begin
    rstrb_raw    = 1'b0;
    wstrb_raw    = 1'b0;
    addr_sel_raw = 1'b0;
    instr_we_raw = 1'b0;
    regs_we_raw  = 1'b0;
    pc_we_raw    = 1'b0;
    rf_we_raw    = 1'b0;
    rf_sel_raw   = 1'b0;
    retire       = 1'b0;
    consume_step = 1'b0;
    case (cur_state)
      S_FETCH_INSTR: begin
        if (can_go) begin
          rstrb_raw    = 1'b1;
          consume_step = 1'b1;
        end
      end
      S_WAIT_INSTR: instr_we_raw = !mem_rbusy;
      S_FETCH_REGS: regs_we_raw  = 1'b1;
      S_EXECUTE: begin
        if (!is_system) begin
          pc_we_raw = 1'b1;
          if (!is_load && !is_store) begin
            rf_we_raw = writes_rd & rd_nonzero;
            retire    = 1'b1;
          end
        end
      end
      S_LOAD: begin
        rstrb_raw    = 1'b1;
        addr_sel_raw = 1'b1;
      end
      S_WAIT_DATA: begin
        addr_sel_raw = 1'b1;
        if (!mem_rbusy) begin
          rf_we_raw  = rd_nonzero;
          rf_sel_raw = 1'b1;
          retire     = 1'b1;
        end
      end
      S_STORE: begin
        wstrb_raw    = 1'b1;
        addr_sel_raw = 1'b1;
      end
      S_WAIT_STORE: retire = !mem_wbusy;
      // Resuming steps the PC past the EBREAK, which counts as retiring it.
      S_HALT: begin
        if (resume) begin
          pc_we_raw = 1'b1;
          retire    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Strobes are held low throughout reset so no access leaks out mid-reset.
  assign mem_rstrb    = rstrb_raw    & resetn;
  assign mem_wstrb    = wstrb_raw    & resetn;
  assign mem_addr_sel = addr_sel_raw & resetn;
  assign instr_we     = instr_we_raw & resetn;
  assign regs_we      = regs_we_raw  & resetn;
  assign pc_we        = pc_we_raw    & resetn;
  assign rf_we        = rf_we_raw    & resetn;
  assign rf_sel_load  = rf_sel_raw   & resetn;

  assign halted = (cur_state == S_HALT) || ((cur_state == S_FETCH_INSTR) && !can_go);
  assign fault  = (cur_state == S_FAULT);
  assign state  = cur_state;

  // Single-step latch: a fetch that consumes the step also absorbs a coincident pulse.
  always_ff @(posedge clk) begin
    if (!resetn || run_mode) step_pending <= 1'b0;
    else if (consume_step)   step_pending <= 1'b0;
    else if (step_req)       step_pending <= 1'b1;
  end

  // Busy-cycle counter; held at zero outside wait states so each wait starts fresh.
  always_ff @(posedge clk) begin
    if (!resetn || !in_wait) to_count <= 8'd0;
    else if (busy_now)       to_count <= to_count + 8'd1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (!resetn)     instr_count <= '0;
    else if (retire) instr_count <= instr_count + COUNT_W'(1);
  end

`ifdef CTRL_PERF_EN
  // Free-running cycle and stall counters for performance monitoring.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if ((in_wait && busy_now) || ((cur_state == S_FETCH_INSTR) && !can_go))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_ctrl_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rv_ctrl_sequencer                                         |
// | Description : Directed self-checking bench for rv_ctrl_sequencer.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rv_ctrl_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, is_load, is_store, is_system, writes_rd, rd_nonzero;
  logic mem_rbusy, mem_wbusy, run_mode, step_req, resume;

  logic mem_rstrb, mem_wstrb, mem_addr_sel, instr_we, regs_we, pc_we;
  logic rf_we, rf_sel_load, halted, fault;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic d2_rstrb, d2_wstrb, d2_addr_sel, d2_instr_we, d2_regs_we, d2_pc_we;
  logic d2_rf_we, d2_rf_sel_load, d2_halted, d2_fault;
  logic [3:0]  d2_state;
  logic [31:0] d2_instr_count;

`ifdef CTRL_PERF_EN
  logic [31:0] cycle_count, stall_count, d2_cycle_count, d2_stall_count;
`endif

  rv_ctrl_sequencer #(.RESET_HALTED(0), .BUS_TIMEOUT(4), .COUNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .is_load(is_load), .is_store(is_store),
    .is_system(is_system), .writes_rd(writes_rd), .rd_nonzero(rd_nonzero),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .run_mode(run_mode),
    .step_req(step_req), .resume(resume), .mem_rstrb(mem_rstrb),
    .mem_wstrb(mem_wstrb), .mem_addr_sel(mem_addr_sel), .instr_we(instr_we),
    .regs_we(regs_we), .pc_we(pc_we), .rf_we(rf_we), .rf_sel_load(rf_sel_load),
    .halted(halted), .fault(fault), .state(state), .instr_count(instr_count)
`ifdef CTRL_PERF_EN
    , .cycle_count(cycle_count), .stall_count(stall_count)
`endif
  );

  rv_ctrl_sequencer #(.RESET_HALTED(1), .BUS_TIMEOUT(255), .COUNT_W(32)) dut_halted (
    .clk(clk), .resetn(resetn), .is_load(is_load), .is_store(is_store),
    .is_system(is_system), .writes_rd(writes_rd), .rd_nonzero(rd_nonzero),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .run_mode(run_mode),
    .step_req(step_req), .resume(resume), .mem_rstrb(d2_rstrb),
    .mem_wstrb(d2_wstrb), .mem_addr_sel(d2_addr_sel), .instr_we(d2_instr_we),
    .regs_we(d2_regs_we), .pc_we(d2_pc_we), .rf_we(d2_rf_we),
    .rf_sel_load(d2_rf_sel_load), .halted(d2_halted), .fault(d2_fault),
    .state(d2_state), .instr_count(d2_instr_count)
`ifdef CTRL_PERF_EN
    , .cycle_count(d2_cycle_count), .stall_count(d2_stall_count)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next active edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; is_load = 1'b0; is_store = 1'b0; is_system = 1'b0;
    writes_rd = 1'b1; rd_nonzero = 1'b1; mem_rbusy = 1'b0; mem_wbusy = 1'b0;
    run_mode = 1'b1; step_req = 1'b0; resume = 1'b0;

    // ---------------- reset ----------------
    tick; #1;
    chk("rst_state",       {28'd0, state}, 32'd0);
    chk("rst_rstrb_gated", {31'd0, mem_rstrb}, 32'd0);
    chk("rst_count",       instr_count, 32'd0);
    chk("rst_fault",       {31'd0, fault}, 32'd0);
    chk("rst_halted_state", {28'd0, d2_state}, 32'd8);
    chk("rst_halted_flag", {31'd0, d2_halted}, 32'd1);
    tick;

    // ---------------- 1: ADDI x1,x0,1 ----------------
    resetn = 1'b1; #1;
    chk("t1_c1_state", {28'd0, state}, 32'd0);
    chk("t1_c1_rstrb", {31'd0, mem_rstrb}, 32'd1);
    chk("t1_c1_asel",  {31'd0, mem_addr_sel}, 32'd0);
    chk("t1_c1_pcwe",  {31'd0, pc_we}, 32'd0);
    tick; #1;
    chk("t1_c2_state", {28'd0, state}, 32'd1);
    chk("t1_c2_iwe",   {31'd0, instr_we}, 32'd1);
    chk("t1_c2_rfwe",  {31'd0, rf_we}, 32'd0);
    tick; #1;
    chk("t1_c3_state", {28'd0, state}, 32'd2);
    chk("t1_c3_regswe", {31'd0, regs_we}, 32'd1);
    chk("t1_c3_pcwe",  {31'd0, pc_we}, 32'd0);
    tick; #1;
    chk("t1_c4_state", {28'd0, state}, 32'd3);
    chk("t1_c4_pcwe",  {31'd0, pc_we}, 32'd1);
    chk("t1_c4_rfwe",  {31'd0, rf_we}, 32'd1);
    chk("t1_c4_rfsel", {31'd0, rf_sel_load}, 32'd0);
    tick; #1;
    chk("t1_end_state", {28'd0, state}, 32'd0);
    chk("t1_end_count", instr_count, 32'd1);

    // ---------------- 2: LW x3 with 3 busy cycles ----------------
    is_load = 1'b1; writes_rd = 1'b0;
    tick; tick; #1;                         // fetch, wait_instr
    chk("t2_fr_state", {28'd0, state}, 32'd2);
    tick; #1;
    chk("t2_ex_pcwe",  {31'd0, pc_we}, 32'd1);
    chk("t2_ex_rfwe",  {31'd0, rf_we}, 32'd0);
    tick; #1;
    chk("t2_ld_state", {28'd0, state}, 32'd4);
    chk("t2_ld_rstrb", {31'd0, mem_rstrb}, 32'd1);
    chk("t2_ld_asel",  {31'd0, mem_addr_sel}, 32'd1);
    tick;
    mem_rbusy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t2_wd_busy_state", {28'd0, state}, 32'd5);
      chk("t2_wd_busy_rfwe",  {31'd0, rf_we}, 32'd0);
      chk("t2_wd_busy_rstrb", {31'd0, mem_rstrb}, 32'd0);
      tick;
    end
    mem_rbusy = 1'b0; #1;
    chk("t2_wd_state", {28'd0, state}, 32'd5);
    chk("t2_wd_rfwe",  {31'd0, rf_we}, 32'd1);
    chk("t2_wd_rfsel", {31'd0, rf_sel_load}, 32'd1);
    chk("t2_wd_asel",  {31'd0, mem_addr_sel}, 32'd1);
    tick; #1;
    chk("t2_end_state", {28'd0, state}, 32'd0);
    chk("t2_end_count", instr_count, 32'd2);
    chk("t2_end_rfwe",  {31'd0, rf_we}, 32'd0);

    // ---------------- 3: SW with 2 busy cycles ----------------
    is_load = 1'b0; is_store = 1'b1;
    tick; tick; tick; #1;                   // fetch, wait_instr, fetch_regs
    chk("t3_ex_state", {28'd0, state}, 32'd3);
    chk("t3_ex_pcwe",  {31'd0, pc_we}, 32'd1);
    chk("t3_ex_rfwe",  {31'd0, rf_we}, 32'd0);
    tick; #1;
    chk("t3_st_wstrb", {31'd0, mem_wstrb}, 32'd1);
    chk("t3_st_asel",  {31'd0, mem_addr_sel}, 32'd1);
    tick;
    mem_wbusy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t3_ws_busy_state", {28'd0, state}, 32'd7);
      chk("t3_ws_busy_wstrb", {31'd0, mem_wstrb}, 32'd0);
      chk("t3_ws_busy_rfwe",  {31'd0, rf_we}, 32'd0);
      tick;
    end
    mem_wbusy = 1'b0; #1;
    chk("t3_ws3_state", {28'd0, state}, 32'd7);
    chk("t3_ws3_rfwe",  {31'd0, rf_we}, 32'd0);
    tick; #1;
    chk("t3_end_state", {28'd0, state}, 32'd0);
    chk("t3_end_count", instr_count, 32'd3);

    // ---------------- 4: EBREAK halt / resume ----------------
    is_store = 1'b0; is_system = 1'b1;
    tick; tick; tick; #1;
    chk("t4_ex_pcwe", {31'd0, pc_we}, 32'd0);
    tick;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_halt_state", {28'd0, state}, 32'd8);
      chk("t4_halt_flag",  {31'd0, halted}, 32'd1);
      chk("t4_halt_pcwe",  {31'd0, pc_we}, 32'd0);
      tick;
    end
    resume = 1'b1; #1;
    chk("t4_resume_pcwe", {31'd0, pc_we}, 32'd1);
    tick;
    resume = 1'b0;
    // Drop free-run before the next edge so the fetch idles for the step test.
    run_mode = 1'b0; is_system = 1'b0; writes_rd = 1'b1; #1;
    chk("t4_end_state", {28'd0, state}, 32'd0);
    chk("t4_end_count", instr_count, 32'd4);
    chk("t4_end_pcwe",  {31'd0, pc_we}, 32'd0);

    // ---------------- 5: single-step with two pulses ----------------
    chk("t5_idle_halted", {31'd0, halted}, 32'd1);
    chk("t5_idle_rstrb",  {31'd0, mem_rstrb}, 32'd0);
    tick;
    step_req = 1'b1; #1;
    chk("t5_p1_rstrb", {31'd0, mem_rstrb}, 32'd0);
    tick; #1;                               // second pulse, step now armed
    chk("t5_p2_rstrb",  {31'd0, mem_rstrb}, 32'd1);
    chk("t5_p2_halted", {31'd0, halted}, 32'd0);
    tick;
    step_req = 1'b0;
    tick; tick; #1;
    chk("t5_ex_pcwe", {31'd0, pc_we}, 32'd1);
    tick; #1;
    chk("t5_end_count",  instr_count, 32'd5);
    chk("t5_end_halted", {31'd0, halted}, 32'd1);
    tick; tick; #1;
    chk("t5_idle_state", {28'd0, state}, 32'd0);
    chk("t5_idle_rstrb2", {31'd0, mem_rstrb}, 32'd0);
    chk("t5_idle_count", instr_count, 32'd5);

    // ---------------- 6: bus timeout (BUS_TIMEOUT=4) ----------------
    run_mode = 1'b1; #1;
    chk("t6_f_rstrb", {31'd0, mem_rstrb}, 32'd1);
    tick;
    mem_rbusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_wait_state", {28'd0, state}, 32'd1);
      chk("t6_wait_iwe",   {31'd0, instr_we}, 32'd0);
      tick;
    end
    #1;
    chk("t6_fault_state", {28'd0, state}, 32'd9);
    chk("t6_fault_flag",  {31'd0, fault}, 32'd1);
    mem_rbusy = 1'b0;
    tick; #1;
    chk("t6_stuck_state", {28'd0, state}, 32'd9);
    chk("t6_stuck_strobes",
        {24'd0, mem_rstrb, mem_wstrb, instr_we, regs_we, pc_we, rf_we, rf_sel_load, mem_addr_sel},
        32'd0);
    chk("t6_stuck_count", instr_count, 32'd5);
    resetn = 1'b0;
    tick; #1;
    chk("t6_rst_state", {28'd0, state}, 32'd0);
    chk("t6_rst_fault", {31'd0, fault}, 32'd0);
    chk("t6_rst_count", instr_count, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv_ctrl_sequencer.md
Name: rv_ctrl_sequencer

Overview:
Multi-cycle control sequencer for the FemtoRV-style datapath in the SOC. It drives the latch and write-enable strobes (instr, rs1/rs2, PC, register file) and the shared memory-port strobes. It adds load/store wait states, EBREAK halt/resume, single-step debug control and a bus-timeout fault. The datapath keeps decode, ALU, nextPC and register bank; this block only decides when each is updated.

Parameters:
RESET_HALTED, 0, 1 = leave reset in HALT instead of FETCH_INSTR.
BUS_TIMEOUT, 255, max consecutive busy cycles in a wait state before FAULT; 0 = timeout disabled; counter width 8.
COUNT_W, 32, width of instr_count.

Ports:
clk  in  1  system clock (post-Clockworks).
resetn  in  1  synchronous, active-low reset.
is_load  in  1  decoded load class of the current instr.
is_store  in  1  decoded store class.
is_system  in  1  decoded SYSTEM (EBREAK).
writes_rd  in  1  ALUreg|ALUimm|JAL|JALR|LUI|AUIPC.
rd_nonzero  in  1  rdId != 0.
mem_rbusy  in  1  read in progress; rdata valid in any cycle after rstrb with rbusy=0.
mem_wbusy  in  1  write in progress.
run_mode  in  1  1 = free run, 0 = single-step.
step_req  in  1  step pulse.
resume  in  1  leave HALT pulse.
mem_rstrb  out  1  read strobe, one cycle.
mem_wstrb  out  1  write strobe, one cycle.
mem_addr_sel  out  1  0 = PC, 1 = rs1+imm.
instr_we  out  1  latch MEM rdata into instr.
regs_we  out  1  latch rs1/rs2.
pc_we  out  1  PC <= nextPC.
rf_we  out  1  register-file write.
rf_sel_load  out  1  write-back source = load data.
halted  out  1  in HALT, or idle in FETCH_INSTR awaiting a step.
fault  out  1  in FAULT.
state  out  4  current state code.
instr_count  out  COUNT_W  retired instructions.

Behaviour:
- States: FETCH_INSTR=0, WAIT_INSTR=1, FETCH_REGS=2, EXECUTE=3, LOAD=4, WAIT_DATA=5, STORE=6, WAIT_STORE=7, HALT=8, FAULT=9.
- Strobes are decoded combinationally from the registered state and inputs.
- All strobes are forced 0 while resetn=0.
- Reset:
  - state becomes FETCH_INSTR, or HALT if RESET_HALTED=1.
  - instr_count=0, step_pending=0, timeout counter=0.
  - Any in-flight access is abandoned without further strobes.
- FETCH_INSTR:
  - Proceeds only if run_mode=1 or step_pending=1. Otherwise it stays and halted=1.
  - On proceed: mem_rstrb=1, addr_sel=0, step_pending cleared, go to WAIT_INSTR.
- WAIT_INSTR:
  - While rbusy=1, stay.
  - When rbusy=0: instr_we=1, go to FETCH_REGS.
- FETCH_REGS: regs_we=1, go to EXECUTE.
- EXECUTE:
  - is_system: go to HALT; pc_we=0.
  - is_load: pc_we=1, go to LOAD.
  - is_store: pc_we=1, go to STORE.
  - Otherwise: pc_we=1, rf_we=writes_rd&rd_nonzero, instr_count+1, go to FETCH_INSTR.
- LOAD: mem_rstrb=1, addr_sel=1, go to WAIT_DATA.
  - The datapath holds the load address from the rs1/instr latches, not from PC.
- WAIT_DATA:
  - When rbusy=0: rf_we=rd_nonzero, rf_sel_load=1, addr_sel=1, instr_count+1, go to FETCH_INSTR.
- STORE: mem_wstrb=1, addr_sel=1, go to WAIT_STORE.
- WAIT_STORE:
  - When wbusy=0: instr_count+1, go to FETCH_INSTR.
  - rf_we is never asserted for stores.
- HALT:
  - halted=1.
  - On resume=1: pc_we=1 (steps past EBREAK), instr_count+1, go to FETCH_INSTR.
  - step_req in the same cycle is still latched.
- FAULT: fault=1, no strobes; exit only via reset.
- step_pending:
  - Set by step_req in any state and held.
  - Multiple pulses before consumption yield one step.
  - Ignored (cleared) when run_mode=1.
- Timeout:
  - Counter clears on entry to each wait state and increments per busy cycle.
  - If busy is still high when count==BUS_TIMEOUT-1, go to FAULT next cycle.
  - Inactive when BUS_TIMEOUT=0.
- instr_count wraps modulo 2^COUNT_W.
- Zero-wait ALU instruction latency: 4 cycles. Zero-wait load or store: 6 cycles.

Optional Feature:
CTRL_PERF_EN:
- Defined: adds outputs cycle_count[31:0] (increments every non-reset cycle) and stall_count[31:0] (increments each cycle in a wait state with busy=1, or in FETCH_INSTR idle). Both reset to 0 and wrap.
- Undefined: these ports and their counters are absent.

Test Plan:
1. Reset, run_mode=1, zero-wait memory, ADDI x1,x0,1 -> states 0,1,2,3. pc_we and rf_we high only in cycle 4. instr_count=1.
2. LW x3 with rbusy held 3 cycles in WAIT_DATA -> rf_we+rf_sel_load exactly one cycle, the cycle rbusy falls. mem_rstrb pulsed once with addr_sel=1. Total 9 cycles.
3. SW with wbusy high 2 cycles -> mem_wstrb one cycle. rf_we never high. Return to FETCH_INSTR on the 3rd WAIT_STORE cycle.
4. EBREAK -> HALT, halted=1, pc_we=0 for 10 cycles. resume pulse -> pc_we one cycle, state 0, instr_count incremented.
5. run_mode=0, two step_req pulses during one fetch -> exactly one instruction retires, then halted=1 idle in FETCH_INSTR.
6. BUS_TIMEOUT=4, rbusy stuck high in WAIT_INSTR -> FAULT after 4 busy cycles, fault=1, no strobes. Assert resetn=0 -> state 0, fault=0.
